// File: rtl/handshake_rr_ctrl.sv
// rtl/handshake_rr_ctrl.sv - round-robin four-phase req/ack handshake controller
module handshake_rr_ctrl #(
  parameter int N_CH      = 4,
  parameter int ACK_DELAY = 2,
  parameter int TIMEOUT   = 16,
  localparam int CW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  output logic [N_CH-1:0] ack,
  output logic            busy,
  output logic [CW-1:0]   grant_id,
  output logic            timeout_err,
  output logic            proto_err
);

  // Delay counter holds 0..ACK_DELAY-1, ack-high counter holds 0..TIMEOUT-1.
  localparam int DW = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ACK   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   last_q, last_d;
  logic [CW-1:0]   grant_q, grant_d;
  logic [N_CH-1:0] ack_q, ack_d;
  logic [DW-1:0]   dly_q, dly_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            terr_q, terr_d;
  logic            perr_q, perr_d;

  logic            any_req;
  logic [CW-1:0]   pick;
  logic [CW-1:0]   idx;

  // Round-robin search: scan offsets from far to near so the nearest set bit after last wins.
  always_comb begin
    any_req = 1'b0;
    pick    = last_q;
    idx     = '0;
    for (int i = N_CH; i >= 1; i--) begin
      idx = CW'((int'(last_q) + i) % N_CH);
      if (req[idx]) begin
        any_req = 1'b1;
        pick    = idx;
      end
    end
  end

  // State register and all datapath registers; async reset returns to idle with channel 0 first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= CW'(N_CH - 1);
      grant_q <= '0;
      ack_q   <= '0;
      dly_q   <= '0;
      tcnt_q  <= '0;
      terr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      dly_q   <= dly_d;
      tcnt_q  <= tcnt_d;
      terr_q  <= terr_d;
      perr_q  <= perr_d;
    end
  end

  // Next-state logic: grant, ack delay, completion, timeout and protocol-error handling.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    ack_d   = ack_q;
    dly_d   = dly_q;
    tcnt_d  = tcnt_q;
    terr_d  = 1'b0;
    perr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          last_d  = pick;
          grant_d = pick;
          if (ACK_DELAY == 0) begin
            ack_d       = '0;
            ack_d[pick] = 1'b1;
            tcnt_d      = '0;
            state_d     = S_ACK;
          end else begin
            dly_d   = DW'(ACK_DELAY - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A dropped request wins over the final delay edge: the requester gave up.
        if (!req[grant_q]) begin
          perr_d  = 1'b1;
          state_d = S_IDLE;
        end else if (dly_q == '0) begin
          ack_d          = '0;
          ack_d[grant_q] = 1'b1;
          tcnt_d         = '0;
          state_d        = S_ACK;
        end else begin
          dly_d = dly_q - DW'(1);
        end
      end
      S_ACK: begin
        // Release at the timeout edge still counts as a normal completion.
        if (!req[grant_q]) begin
          ack_d   = '0;
          state_d = S_IDLE;
        end else if ((TIMEOUT > 0) && (tcnt_q == TW'(TIMEOUT - 1))) begin
          ack_d   = '0;
          terr_d  = 1'b1;
          state_d = S_DRAIN;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_DRAIN: begin
        if (!req[grant_q]) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        ack_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs come straight from registers so they clear immediately on async reset.
  always_comb begin
    ack         = ack_q;
    busy        = (state_q != S_IDLE);
    grant_id    = grant_q;
    timeout_err = terr_q;
    proto_err   = perr_q;
  end

endmodule

// File: tb/tb_handshake_rr_ctrl.sv
// tb/tb_handshake_rr_ctrl.sv - self-checking bench for handshake_rr_ctrl
module tb_handshake_rr_ctrl;

  localparam int N  = 4;
  localparam int AD = 2;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] ack;
  logic       busy;
  logic [1:0] grant_id;
  logic       timeout_err;
  logic       proto_err;

  int n_tests = 0;
  int n_fail  = 0;
  int model_last;

  handshake_rr_ctrl #(.N_CH(N), .ACK_DELAY(AD), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .ack        (ack),
    .busy       (busy),
    .grant_id   (grant_id),
    .timeout_err(timeout_err),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requesting channel searching upward from last+1, wrapping.
  function automatic int rr_pick(input int last, input logic [3:0] mask);
    for (int i = 1; i <= N; i++) begin
      int c;
      c = (last + i) % N;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full handshake: grant, ack after AD cycles, hold, release.
  task automatic hs(input logic [3:0] mask, input int hold, output int g_dut);
    int         g;
    logic [3:0] oh;
    g = rr_pick(model_last, mask);
    model_last = g;
    oh = '0;
    oh[g] = 1'b1;
    req = mask;
    step();
    g_dut = int'(grant_id);
    chk("grant_id", 32'(grant_id), 32'(g));
    chk("busy_grant", 32'(busy), 32'd1);
    chk("ack_wait", 32'(ack), 32'd0);
    chk("perr_clear", 32'(proto_err), 32'd0);
    for (int d = 1; d < AD; d++) begin
      step();
      chk("ack_wait", 32'(ack), 32'd0);
    end
    step();
    chk("ack_on", 32'(ack), 32'(oh));
    chk("no_err", 32'({timeout_err, proto_err}), 32'd0);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("ack_hold", 32'(ack), 32'(oh));
    end
    req = mask & ~oh;
    step();
    chk("ack_rel", 32'(ack), 32'd0);
    chk("busy_rel", 32'(busy), 32'd0);
    chk("terr_rel", 32'(timeout_err), 32'd0);
  endtask

  // Granted request dropped after w WAIT cycles: proto_err, no ack.
  task automatic hs_proto(input logic [3:0] mask, input int w);
    int         g;
    logic [3:0] oh;
    g = rr_pick(model_last, mask);
    model_last = g;
    oh = '0;
    oh[g] = 1'b1;
    req = mask;
    step();
    chk("p_grant_id", 32'(grant_id), 32'(g));
    chk("p_busy", 32'(busy), 32'd1);
    chk("p_perr0", 32'(proto_err), 32'd0);
    for (int d = 0; d < w; d++) begin
      step();
      chk("p_ack_wait", 32'(ack), 32'd0);
    end
    req = mask & ~oh;
    step();
    chk("proto_err", 32'(proto_err), 32'd1);
    chk("p_terr", 32'(timeout_err), 32'd0);
    chk("p_ack", 32'(ack), 32'd0);
    chk("p_busy_rel", 32'(busy), 32'd0);
  endtask

  initial begin
    int gd;
    int exp_a[5];
    int exp_b[3];
    exp_a = '{0, 1, 2, 3, 0};
    exp_b = '{1, 3, 1};

    // Reset held with all requests high.
    rst = 1'b1;
    req = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_err", 32'({timeout_err, proto_err}), 32'd0);
    req = 4'h0;
    rst = 1'b0;
    model_last = N - 1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_quiet", 32'({ack, busy, grant_id, timeout_err, proto_err}), 32'd0);
    end

    // Single channel.
    hs(4'b0100, 0, gd);

    // Round robin from a fresh pointer.
    rst = 1'b1;
    #2;
    chk("pulse_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    model_last = N - 1;
    for (int i = 0; i < 5; i++) begin
      hs(4'hF, 1, gd);
      chk("rr_order_all", 32'(gd), 32'(exp_a[i]));
    end
    for (int i = 0; i < 3; i++) begin
      hs(4'b1010, 0, gd);
      chk("rr_order_1010", 32'(gd), 32'(exp_b[i]));
    end

    // Release exactly at the timeout edge is a normal completion.
    hs(4'b0010, TO - 1, gd);

    // Timeout and drain.
    gd = rr_pick(model_last, 4'b0010);
    model_last = gd;
    req = 4'b0010;
    step();
    chk("to_grant", 32'(grant_id), 32'd1);
    step();
    chk("to_ack_wait", 32'(ack), 32'd0);
    step();
    for (int i = 0; i < TO; i++) begin
      chk("to_ack_high", 32'(ack), 32'h2);
      chk("to_terr_low", 32'(timeout_err), 32'd0);
      step();
    end
    chk("to_ack_fall", 32'(ack), 32'd0);
    chk("to_terr_pulse", 32'(timeout_err), 32'd1);
    chk("to_busy_drain", 32'(busy), 32'd1);
    step();
    chk("to_terr_once", 32'(timeout_err), 32'd0);
    chk("to_drain_ack", 32'(ack), 32'd0);
    step();
    chk("to_drain_busy", 32'(busy), 32'd1);
    req = 4'b0000;
    step();
    chk("to_idle", 32'(busy), 32'd0);

    // Protocol errors: early drop and drop at the last WAIT edge.
    hs_proto(4'b1000, 0);
    hs_proto(4'b0100, AD - 1);

    // Asynchronous reset while ack[0] is high.
    gd = rr_pick(model_last, 4'b0001);
    model_last = gd;
    req = 4'b0001;
    step();
    step();
    step();
    chk("ar_ack_on", 32'(ack), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_ack_async", 32'(ack), 32'd0);
    chk("ar_busy_async", 32'(busy), 32'd0);
    step();
    chk("ar_held", 32'({ack, busy}), 32'd0);
    model_last = N - 1;
    req = 4'hF;
    rst = 1'b0;
    step();
    chk("ar_first_grant", 32'(grant_id), 32'd0);
    chk("ar_busy", 32'(busy), 32'd1);
    model_last = 0;
    step();
    step();
    chk("ar_ack", 32'(ack), 32'h1);
    req = 4'b0000;
    step();
    chk("ar_rel", 32'(busy), 32'd0);

    // Randomized traffic against the round-robin model.
    for (int i = 0; i < 30; i++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 4) == 0) begin
        hs_proto(m, int'($urandom_range(0, AD - 1)));
      end else begin
        hs(m, int'($urandom_range(0, 6)), gd);
      end
    end
    req = 4'b0000;
    step();
    chk("final_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
